// File: rtl/mips_instr_encoder_if.sv
// Mnemonic/opcode package plus the encoder's control, input-beat and output-stream bus.
// The encoder drives the slave side; a program loader or bench drives the master side.
package mips_pkg;
  typedef enum logic [4:0] {
    NEM_ZERO, ADD, ADDI, ADDIU, AND, BEQ, JUMP, LW,
    OR, SLT, SUB, SW, XOR, ABS, NOR, SLL
  } t_instr_pnmen;

  localparam logic [5:0] OP_ZERO  = 6'h00;
  localparam logic [5:0] OP_JUMP  = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ABS   = 6'h1C;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_SLT = 6'h2A;
endpackage

interface mips_instr_encoder_if #(parameter int ADDR_W = 8);
  logic                     start;
  logic [ADDR_W-1:0]        base_addr;
  logic                     in_valid;
  logic                     in_ready;
  logic                     in_last;
  mips_pkg::t_instr_pnmen   in_mnem;
  logic [4:0]               in_rs;
  logic [4:0]               in_rt;
  logic [4:0]               in_rd;
  logic [15:0]              in_imm;
  logic [25:0]              in_target;
  logic                     out_valid;
  logic                     out_ready;
  logic [ADDR_W-1:0]        out_addr;
  logic [31:0]              out_word;
  logic                     busy;
  logic                     done;
  logic [ADDR_W:0]          word_count;
  logic                     err_op;
  logic                     err_wrap;

  modport master (
    output start, base_addr, in_valid, in_last, in_mnem, in_rs, in_rt, in_rd,
           in_imm, in_target, out_ready,
    input  in_ready, out_valid, out_addr, out_word, busy, done, word_count,
           err_op, err_wrap
  );

  modport slave (
    input  start, base_addr, in_valid, in_last, in_mnem, in_rs, in_rt, in_rd,
           in_imm, in_target, out_ready,
    output in_ready, out_valid, out_addr, out_word, busy, done, word_count,
           err_op, err_wrap
  );
endinterface

// File: rtl/mips_instr_encoder.sv
// Packs mnemonic+fields into MIPS words and streams {addr, word} through a small registered FIFO.
// Optional MIPS_ENC_DELAY_SLOT_EN: pad a NOP after every BEQ/JUMP.
module mips_instr_encoder
  import mips_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int ADDR_STEP  = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mips_instr_encoder_if.slave   bus
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       word;
  } t_ent;

  typedef enum logic [2:0] {ST_IDLE, ST_RUN, ST_SLOT, ST_DRAIN, ST_DONE} t_state;

  t_state            r_state, w_state_nxt;
  t_ent              r_mem [FIFO_DEPTH];
  logic [PW:0]       r_wptr, r_rptr;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_count;
  logic              r_err_op, r_err_wrap;

  logic              w_empty, w_full, w_push, w_pop, w_accept, w_bad, w_in_ready;
  logic [31:0]       w_word;
  t_ent              w_ent;
  logic [ADDR_W:0]   w_addr_sum;

  assign w_empty    = (r_wptr == r_rptr);
  assign w_full     = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign w_pop      = !w_empty && bus.out_ready;
  assign w_accept   = (r_state == ST_RUN) && bus.in_valid && !w_full;
  // Carry out of the address adder is the wrap indication.
  assign w_addr_sum = {1'b0, r_addr} + (ADDR_W+1)'(ADDR_STEP);

  always_comb begin
    w_word = 32'h0;
    w_bad  = 1'b0;
    case (bus.in_mnem)
      ADD:      w_word = {OP_ZERO, bus.in_rs, bus.in_rt, bus.in_rd, 5'b0, FN_ADD};
      AND:      w_word = {OP_ZERO, bus.in_rs, bus.in_rt, bus.in_rd, 5'b0, FN_AND};
      OR:       w_word = {OP_ZERO, bus.in_rs, bus.in_rt, bus.in_rd, 5'b0, FN_OR};
      SLT:      w_word = {OP_ZERO, bus.in_rs, bus.in_rt, bus.in_rd, 5'b0, FN_SLT};
      SUB:      w_word = {OP_ZERO, bus.in_rs, bus.in_rt, bus.in_rd, 5'b0, FN_SUB};
      XOR:      w_word = {OP_ZERO, bus.in_rs, bus.in_rt, bus.in_rd, 5'b0, FN_XOR};
      ADDI:     w_word = {OP_ADDI,  bus.in_rs, bus.in_rt, bus.in_imm};
      ADDIU:    w_word = {OP_ADDIU, bus.in_rs, bus.in_rt, bus.in_imm};
      BEQ:      w_word = {OP_BEQ,   bus.in_rs, bus.in_rt, bus.in_imm};
      LW:       w_word = {OP_LW,    bus.in_rs, bus.in_rt, bus.in_imm};
      SW:       w_word = {OP_SW,    bus.in_rs, bus.in_rt, bus.in_imm};
      JUMP:     w_word = {OP_JUMP,  bus.in_target};
      ABS:      w_word = {OP_ABS,   bus.in_rs, bus.in_rt, 16'h0};
      NEM_ZERO: w_word = 32'h0;
      default:  w_bad  = 1'b1;
    endcase
  end

`ifdef MIPS_ENC_DELAY_SLOT_EN
  logic r_slot_last;
  logic w_is_br;
  assign w_is_br = (bus.in_mnem == BEQ) || (bus.in_mnem == JUMP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_slot_last <= 1'b0;
    else if (w_accept) r_slot_last <= bus.in_last;
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_push      = 1'b0;
    w_ent       = '{addr: r_addr, word: w_word};
    case (r_state)
      ST_IDLE:  if (bus.start) w_state_nxt = ST_RUN;
      ST_RUN: begin
        w_in_ready = !w_full;
        if (w_accept) begin
          w_push = 1'b1;
`ifdef MIPS_ENC_DELAY_SLOT_EN
          if (w_is_br)          w_state_nxt = ST_SLOT;
          else if (bus.in_last) w_state_nxt = ST_DRAIN;
`else
          if (bus.in_last) w_state_nxt = ST_DRAIN;
`endif
        end
      end
`ifdef MIPS_ENC_DELAY_SLOT_EN
      ST_SLOT: begin
        w_ent.word = 32'h0;
        if (!w_full) begin
          w_push      = 1'b1;
          w_state_nxt = r_slot_last ? ST_DRAIN : ST_RUN;
        end
      end
`endif
      ST_DRAIN: if (w_empty) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_count    <= '0;
      r_err_op   <= 1'b0;
      r_err_wrap <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      if (bus.start) begin
        r_addr     <= bus.base_addr;
        r_count    <= '0;
        r_err_op   <= 1'b0;
        r_err_wrap <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_addr  <= w_addr_sum[ADDR_W-1:0];
        r_count <= r_count + (ADDR_W+1)'(1);
        if (w_addr_sum[ADDR_W]) r_err_wrap <= 1'b1;
      end
      if (w_accept && w_bad) r_err_op <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr[PW-1:0]] <= w_ent;
        r_wptr                <= r_wptr + (PW+1)'(1);
      end
      if (w_pop) r_rptr <= r_rptr + (PW+1)'(1);
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = !w_empty;
  assign bus.out_addr   = r_mem[r_rptr[PW-1:0]].addr;
  assign bus.out_word   = r_mem[r_rptr[PW-1:0]].word;
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.done       = (r_state == ST_DONE);
  assign bus.word_count = r_count;
  assign bus.err_op     = r_err_op;
  assign bus.err_wrap   = r_err_wrap;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed bench for mips_instr_encoder: hand-encoded words, backpressure, wrap, errors, reset abort.
module tb_mips_instr_encoder;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mips_instr_encoder_if #(.ADDR_W(8)) bus ();

  mips_instr_encoder #(.ADDR_W(8), .ADDR_STEP(4), .FIFO_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0;
  logic [7:0]  q_addr [$];
  logic [31:0] q_word [$];

  // Pops happen on the next rising edge; inputs only change at posedge+1.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      q_addr.push_back(bus.out_addr);
      q_word.push_back(bus.out_word);
    end
    if (bus.done) n_done++;
  end

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_prog(logic [7:0] b);
    bus.start = 1'b1;
    bus.base_addr = b;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send(t_instr_pnmen m, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                      logic [15:0] imm, logic [25:0] tg, logic last);
    int n = 0;
    bus.in_valid = 1'b1; bus.in_mnem = m; bus.in_rs = rs; bus.in_rt = rt; bus.in_rd = rd;
    bus.in_imm = imm; bus.in_target = tg; bus.in_last = last;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("send_timeout", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!bus.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", bus.done, 1);
    @(negedge clk);
    chk("done_one_cycle", bus.done, 0);
    chk("idle_after_done", bus.busy, 0);
    tick();
  endtask

  task automatic chk_out(string tag, int idx, logic [7:0] a, logic [31:0] w);
    if (idx < q_addr.size()) begin
      chk({tag, "_addr"}, q_addr[idx], a);
      chk({tag, "_word"}, q_word[idx], w);
    end else begin
      chk({tag, "_missing"}, q_addr.size(), idx + 1);
    end
  endtask

  initial begin
    int b, nd;
    bus.start = 0; bus.base_addr = '0; bus.in_valid = 0; bus.in_last = 0;
    bus.in_mnem = NEM_ZERO; bus.in_rs = '0; bus.in_rt = '0; bus.in_rd = '0;
    bus.in_imm = '0; bus.in_target = '0; bus.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_count", bus.word_count, 0);
    chk("rst_errs", {bus.err_op, bus.err_wrap}, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // single ADD, next-cycle visibility
    b = q_addr.size();
    start_prog(8'h10);
    chk("t1_busy", bus.busy, 1);
    send(ADD, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1);
    chk("t1_lat_valid", bus.out_valid, 1);
    chk("t1_lat_word", bus.out_word, 32'h0022_1820);
    wait_done();
    chk_out("t1", b, 8'h10, 32'h0022_1820);
    chk("t1_n", q_addr.size() - b, 1);
    chk("t1_count", bus.word_count, 1);

    // I/J types; start during RUN must be ignored
    b = q_addr.size();
    start_prog(8'h00);
    send(ADDI, 5'd0, 5'd2, 5'd0, 16'd5, 26'h0, 1'b0);
    start_prog(8'h80);
    send(LW, 5'd9, 5'd8, 5'd0, 16'd4, 26'h0, 1'b0);
    send(JUMP, 5'd0, 5'd0, 5'd0, 16'h0, 26'h100, 1'b1);
    wait_done();
    chk_out("t2_0", b, 8'h00, 32'h2002_0005);
    chk_out("t2_1", b + 1, 8'h04, 32'h8D28_0004);
    chk_out("t2_2", b + 2, 8'h08, 32'h0800_0100);
`ifdef MIPS_ENC_DELAY_SLOT_EN
    chk_out("t2_nop", b + 3, 8'h0C, 32'h0);
    chk("t2_count", bus.word_count, 4);
`else
    chk("t2_count", bus.word_count, 3);
`endif

    // BEQ as last instruction
    b = q_addr.size();
    start_prog(8'h00);
    send(BEQ, 5'd1, 5'd2, 5'd0, 16'd4, 26'h0, 1'b1);
    wait_done();
    chk_out("t3_0", b, 8'h00, 32'h1022_0004);
`ifdef MIPS_ENC_DELAY_SLOT_EN
    chk_out("t3_nop", b + 1, 8'h04, 32'h0);
    chk("t3_n", q_addr.size() - b, 2);
    chk("t3_count", bus.word_count, 2);
`else
    chk("t3_n", q_addr.size() - b, 1);
    chk("t3_count", bus.word_count, 1);
`endif

    // backpressure: FIFO fills after two beats, head held stable
    b = q_addr.size();
    bus.out_ready = 1'b0;
    start_prog(8'h40);
    send(OR, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
    send(SUB, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
    bus.in_valid = 1'b1; bus.in_mnem = XOR; bus.in_last = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t4_in_ready_low", bus.in_ready, 0);
      chk("t4_head_stable", {bus.out_valid, bus.out_addr, bus.out_word}, {1'b1, 8'h40, 32'h0022_1825});
    end
    tick();
    bus.out_ready = 1'b1;
    begin
      int n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    chk("t4_accept", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    wait_done();
    chk("t4_n", q_addr.size() - b, 3);
    chk_out("t4_0", b, 8'h40, 32'h0022_1825);
    chk_out("t4_1", b + 1, 8'h44, 32'h0022_1822);
    chk_out("t4_2", b + 2, 8'h48, 32'h0022_1826);

    // address wrap
    b = q_addr.size();
    start_prog(8'hFC);
    send(ADD, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
    send(ADDI, 5'd0, 5'd2, 5'd0, 16'd5, 26'h0, 1'b1);
    wait_done();
    chk_out("t5_0", b, 8'hFC, 32'h0022_1820);
    chk_out("t5_1", b + 1, 8'h00, 32'h2002_0005);
    chk("t5_err_wrap", bus.err_wrap, 1);
    chk("t5_err_op", bus.err_op, 0);

    // ABS + unsupported mnemonic; start clears sticky flags
    b = q_addr.size();
    start_prog(8'h20);
    chk("t5_wrap_cleared", bus.err_wrap, 0);
    send(ABS, 5'd3, 5'd4, 5'd0, 16'h0, 26'h0, 1'b0);
    send(NOR, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1);
    wait_done();
    chk_out("t5_abs", b, 8'h20, 32'h7064_0000);
    chk_out("t5_bad", b + 1, 8'h24, 32'h0);
    chk("t5_err_op_set", bus.err_op, 1);
    start_prog(8'h30);
    chk("t5_op_cleared", bus.err_op, 0);
    send(ADD, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1);
    wait_done();

    // reset with two words queued
    bus.out_ready = 1'b0;
    start_prog(8'h50);
    send(ADD, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
    send(SUB, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
    chk("t6_busy_pre", bus.busy, 1);
    chk("t6_valid_pre", bus.out_valid, 1);
    nd = n_done;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid_rst", bus.out_valid, 0);
    chk("t6_busy_rst", bus.busy, 0);
    chk("t6_count_rst", bus.word_count, 0);
    repeat (3) @(negedge clk);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("t6_no_done", n_done - nd, 0);
    chk("t6_idle", bus.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
